// File: rtl/multi_port_mem_ctrl.sv
// multi_port_mem_ctrl
//   Byte-serial controller that lets NUM_PORTS requesters share one 8-bit RAM
//   port. Requesters are picked round-robin. Each port can issue byte, half or
//   word loads and stores. Loads can be sign- or zero-extended. A masked port's
//   load can be aborted by clearIn. Stores always run to completion.
//
// Ports
//   clockIn, resetIn   : rising-edge clock, async active-high reset
//   readyIn            : global enable (low freezes every register)
//   clearIn            : mispredict flush for ports selected by CLEAR_MASK
//   reqIn/weIn/sizeIn  : per-port request, store flag, {zext, size[1:0]}
//   addrIn/wdataIn     : per-port byte address and little-endian store data
//   okOut              : one-cycle completion pulse per port
//   rdataOut           : extended data of the last completed load
//   grantOut           : index of the current or last granted port
//   busyOut            : transaction in flight
//   ramSelect/ramAddr/ramOut/ramIn : RAM interface (1 = read, 0 = write)
module multi_port_mem_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int NUM_PORTS = 2,
  parameter logic [NUM_PORTS-1:0] CLEAR_MASK = {NUM_PORTS{1'b1}},
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    clockIn,
  input  logic                    resetIn,
  input  logic                    readyIn,
  input  logic                    clearIn,
  input  logic [NUM_PORTS-1:0]    reqIn,
  input  logic [NUM_PORTS-1:0]    weIn,
  input  logic [3*NUM_PORTS-1:0]  sizeIn,
  input  logic [32*NUM_PORTS-1:0] addrIn,
  input  logic [32*NUM_PORTS-1:0] wdataIn,
  output logic [NUM_PORTS-1:0]    okOut,
  output logic [31:0]             rdataOut,
  output logic [GW-1:0]           grantOut,
  output logic                    busyOut,
  output logic                    ramSelect,
  output logic [ADDR_WIDTH-1:0]   ramAddr,
  output logic [7:0]              ramOut,
  input  logic [7:0]              ramIn
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic                  we_q, we_d;
  logic [2:0]            size_q, size_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           buf_q, buf_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [NUM_PORTS-1:0]  ok_q, ok_d;

  logic [31:0]           addr_a  [NUM_PORTS];
  logic [31:0]           wdata_a [NUM_PORTS];
  logic [2:0]            size_a  [NUM_PORTS];

  logic [NUM_PORTS-1:0]  elig_s;
  logic                  win_vld_s;
  logic [GW-1:0]         win_s;
  logic [GW-1:0]         idx_s;
  logic [2:0]            last_s;
  logic [2:0]            rd_idx_s;
  logic [31:0]           merged_s;
  logic [ADDR_WIDTH-1:0] cur_addr_s;
  logic                  unused_addr_s;

  // Index of the last byte of a transfer: 0, 1 or 3.
  function automatic logic [2:0] last_byte(input logic [1:0] sz);
    logic [2:0] r;
    case (sz)
      2'b00:   r = 3'd0;
      2'b01:   r = 3'd1;
      default: r = 3'd3;
    endcase
    return r;
  endfunction

  // Replace one byte lane of a word.
  function automatic logic [31:0] put_byte(input logic [31:0] d, input logic [1:0] sel,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = d;
    r[{sel, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Sign- or zero-extend a loaded value from its top byte.
  function automatic logic [31:0] extend_load(input logic [31:0] d, input logic [2:0] sz);
    logic [31:0] r;
    case (sz[1:0])
      2'b00:   r = sz[2] ? {24'h000000, d[7:0]} : {{24{d[7]}}, d[7:0]};
      2'b01:   r = sz[2] ? {16'h0000, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign addr_a[p]  = addrIn[32*p +: 32];
    assign wdata_a[p] = wdataIn[32*p +: 32];
    assign size_a[p]  = sizeIn[3*p +: 3];
  end

  // Address bits above ADDR_WIDTH are intentionally ignored.
  assign unused_addr_s = ^addrIn;

  assign last_s     = last_byte(size_q[1:0]);
  assign rd_idx_s   = cnt_q - 3'd1;
  assign merged_s   = put_byte(buf_q, rd_idx_s[1:0], ramIn);
  assign cur_addr_s = addr_a[grant_q][ADDR_WIDTH-1:0] + ADDR_WIDTH'(cnt_q);

  // Round-robin arbiter. A port whose okOut is high is skipped, so a held
  // request is not served twice.
  always_comb begin
    elig_s    = reqIn & ~ok_q & ~(clearIn ? CLEAR_MASK : '0);
    win_vld_s = 1'b0;
    win_s     = grant_q;
    idx_s     = grant_q;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx_s = GW'((int'(grant_q) + k) % NUM_PORTS);
      if (!win_vld_s && elig_s[idx_s]) begin
        win_vld_s = 1'b1;
        win_s     = idx_s;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      state_q <= IDLE;
      grant_q <= GW'(NUM_PORTS - 1);
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      cnt_q   <= 3'd0;
      buf_q   <= 32'h0;
      rdata_q <= 32'h0;
      ok_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      ok_q    <= ok_d;
    end
  end

  // Next-state and datapath update; everything holds while readyIn is low.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    we_d    = we_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    ok_d    = ok_q;
    if (readyIn) begin
      ok_d = '0;
      case (state_q)
        IDLE: begin
          if (win_vld_s) begin
            grant_d = win_s;
            we_d    = weIn[win_s];
            size_d  = size_a[win_s];
            // Byte 0 of a load is already being read during this cycle.
            cnt_d   = weIn[win_s] ? 3'd0 : 3'd1;
            buf_d   = 32'h0;
            state_d = weIn[win_s] ? WRITE : READ;
          end else begin
            state_d = IDLE;
          end
        end
        READ: begin
          if (clearIn && CLEAR_MASK[grant_q]) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else if (rd_idx_s == last_s) begin
            buf_d          = merged_s;
            rdata_d        = extend_load(merged_s, size_q);
            ok_d[grant_q]  = 1'b1;
            cnt_d          = 3'd0;
            state_d        = IDLE;
          end else begin
            buf_d = merged_s;
            cnt_d = cnt_q + 3'd1;
          end
        end
        WRITE: begin
          if (cnt_q == last_s) begin
            ok_d[grant_q] = 1'b1;
            cnt_d         = 3'd0;
            state_d       = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // RAM-side outputs. In IDLE the winner's address goes out immediately.
  always_comb begin
    ramSelect = 1'b1;
    ramOut    = 8'h00;
    ramAddr   = addr_a[0][ADDR_WIDTH-1:0];
    case (state_q)
      IDLE: begin
        if (win_vld_s) begin
          ramAddr = addr_a[win_s][ADDR_WIDTH-1:0];
        end else begin
          ramAddr = addr_a[0][ADDR_WIDTH-1:0];
        end
      end
      READ: begin
        ramAddr = cur_addr_s;
      end
      WRITE: begin
        ramAddr   = cur_addr_s;
        ramOut    = wdata_a[grant_q][{cnt_q[1:0], 3'b000} +: 8];
        ramSelect = ~readyIn;
      end
      default: begin
        ramAddr = addr_a[0][ADDR_WIDTH-1:0];
      end
    endcase
  end

  assign okOut    = ok_q;
  assign rdataOut = rdata_q;
  assign grantOut = grant_q;
  assign busyOut  = (state_q != IDLE);

endmodule

// File: doc/multi_port_mem_ctrl.md
Name: multi_port_mem_ctrl

Overview:
Byte-serial RAM controller serving NUM_PORTS requesters, e.g. icache, LSB and a future DMA/debug port, through round-robin arbitration. Each port issues byte, halfword or word loads and stores. Loads are sign- or zero-extended. Speculative reads are abortable per port on branch-mispredict clear; stores always complete. Sits between the fetch/LSB units and the single 8-bit RAM port.

Parameters:
ADDR_WIDTH, 17, RAM address width; generated byte addresses wrap modulo 2^ADDR_WIDTH.
NUM_PORTS, 2, requester count, 1..8; port 0 is lowest index.
CLEAR_MASK, all ones (NUM_PORTS bits), bit p=1 means clearIn aborts port p reads.
GW, max(1,clog2(NUM_PORTS)), grant index width (localparam).

Ports:
clockIn  in  1  clock, rising edge.
resetIn  in  1  asynchronous, active-high reset.
readyIn  in  1  global enable; low freezes controller.
clearIn  in  1  mispredict flush.
reqIn  in  NUM_PORTS  request per port; held high until okOut of that port.
weIn  in  NUM_PORTS  1=store, 0=load.
sizeIn  in  3*NUM_PORTS  per port [1:0]: 00 byte, 01 half, 10/11 word; [2]: 1=zero-extend load.
addrIn  in  32*NUM_PORTS  per-port byte address.
wdataIn  in  32*NUM_PORTS  per-port store data, little-endian.
okOut  out  NUM_PORTS  one-cycle completion pulse.
rdataOut  out  32  extended load data; valid while okOut pulses for a load.
grantOut  out  GW  index of current/last granted port.
busyOut  out  1  high in READ/WRITE states.
ramSelect  out  1  1=read, 0=write.
ramAddr  out  ADDR_WIDTH  RAM byte address.
ramOut  out  8  write byte.
ramIn  in  8  read byte; valid one cycle after its address.

Behaviour:
- Reset: state IDLE, okOut=0, rdataOut=0, grantOut=NUM_PORTS-1 (port 0 wins first), busyOut=0, ramSelect=1, ramOut=0, byte counter=0.
- readyIn=0: no register changes, ramSelect forced 1 (no RAM write), other outputs held.
- Let n=1/2/4 bytes for size 00/01/1x.
- IDLE, arbitration: eligible ports have reqIn=1 and okOut=0 this cycle. If clearIn=1, ports with CLEAR_MASK set are also excluded. Winner is the first eligible port scanning from grantOut+1 upward, wrapping. ramAddr combinationally = winner addrIn (byte 0) so the RAM read starts immediately. With no request, ramAddr = addrIn of port 0.
- Grant latches port, we, size and byte counter i=1 (load) or i=0 (store). Next state is READ or WRITE.
- READ: ramAddr = addr+i. On each ready cycle, capture ramIn into byte i-1 of the buffer. After capturing byte n-1, go IDLE. On the same edge set okOut[g]=1 and rdataOut = buffer with byte n-1 merged, extended from bit 8n-1 (sign) or zero (size[2]=1). Load latency: n+1 ready cycles from grant edge to okOut.
- WRITE: ramSelect=0, ramAddr = addr+i, ramOut = wdata byte i. After byte n-1 is written, go IDLE with okOut[g]=1. Latency: n+1 ready cycles from grant.
- okOut deasserts after one ready cycle. rdataOut holds until the next load completes.
- Requester may change addr/data after okOut. Controller samples addrIn/wdataIn of the granted port every cycle; ports must hold them stable until okOut.
- clearIn=1 with readyIn=1:
  - READ of a masked port: return to IDLE, counter=0, no okOut, rdataOut unchanged.
  - Pending okOut of a masked port forced 0.
  - WRITE and unmasked ports: unaffected.
  - clearIn with readyIn=0: ignored.
- Simultaneous okOut[p] and reqIn[p]: p is not re-granted that cycle, which prevents a double service.
- Address wrap: addr+i truncated to ADDR_WIDTH; e.g. word at 2^ADDR_WIDTH-1 touches 1FFFF, 0, 1, 2.
- reqIn dropped mid-transaction: transaction completes normally, okOut still pulses.
- resetIn mid-transaction: immediate IDLE, no okOut, a partial store is not retried.

Test Plan:
- Port 1 lw 0x100, RAM bytes 11 22 33 44 -> okOut=2'b10 on 5th cycle after grant, rdataOut=0x44332211.
- Ports 0 and 1 both request loads continuously -> grants alternate 0,1,0,1; neither port starves.
- lb 0x80 with byte 0xF0, sizeIn=000 -> rdataOut=0xFFFFFFF0; sizeIn=100 -> 0x000000F0.
- sh wdata 0xABCD at 0x1FFFF -> ramSelect=0 writes CD@0x1FFFF then AB@0x00000, then one okOut pulse.
- lw in progress on port 0, clearIn after 2 bytes -> IDLE, no okOut. Repeat during sw -> all 4 bytes written, okOut pulses.
- readyIn low 3 cycles mid-lw -> latency grows by 3 and data is still correct; resetIn asserted mid-READ -> all outputs at reset values asynchronously.
